// File: rtl/countdown_timer.sv
//-----------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counting timer. A terminal value is loaded, the timer is
// started, and it counts down to zero. Expiry is flagged by a registered
// one-cycle done pulse. The timer can be paused and resumed, aborted, and
// placed in auto-reload mode so that it produces a periodic tick.
//
// Parameters
//   WIDTH        counter / load-value width in bits
//
// Ports
//   clk          single clock, all logic on its rising edge
//   rst          synchronous, active-high reset
//   load         capture data into count and the reload register (any state)
//   data         value captured on load
//   start        begin counting; honoured in IDLE only and only if count != 0
//   pause        level; freezes the count while high (RUN/PAUSE)
//   stop         abort to IDLE; count holds, no done
//   auto_reload  sampled on the terminal edge: reload instead of stopping
//   count        current count value (registered)
//   busy         high while state != IDLE (registered)
//   done         one-cycle pulse on the terminal edge (registered)
//
// Per-edge priority: rst > load > stop > pause > start/decrement.
//-----------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] reload_next;
    logic             done_next;

    //-------------------------------------------------------------------------
    // Next-state / next-output logic
    //-------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next  = state;
        count_next  = count;
        reload_next = reload_val;
        done_next   = 1'b0;

        if (load) begin
            // Load wins over everything except reset and always parks in IDLE.
            count_next  = data;
            reload_next = data;
            state_next  = IDLE;
        end else if (stop && (state != IDLE)) begin
            // Abort: count is left where it was so a later start resumes it.
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    // Starting from zero would expire immediately with nothing
                    // to count, so it is refused. The start edge itself does
                    // not decrement.
                    if (start && (count != CNT_ZERO)) begin
                        state_next = RUN;
                    end
                end

                RUN: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else if (count > CNT_ONE) begin
                        count_next = count - CNT_ONE;
                    end else if (count == CNT_ONE) begin
                        // Terminal edge: the only edge on which done is raised.
                        done_next = 1'b1;
                        if (auto_reload) begin
                            count_next = reload_val;
                        end else begin
                            count_next = CNT_ZERO;
                            state_next = IDLE;
                        end
                    end else begin
                        // Zero while running cannot be reached through start;
                        // fall back to IDLE rather than wrap below zero.
                        state_next = IDLE;
                    end
                end

                PAUSE: begin
                    // Resume edge does not decrement; counting restarts on the
                    // edge after.
                    if (!pause) begin
                        state_next = RUN;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // State and output registers
    //-------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register here is small control/data state and is
            // reset; a pending done is discarded by clearing it on this edge.
            state      <= IDLE;
            count      <= CNT_ZERO;
            reload_val <= CNT_ZERO;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_val <= reload_next;
            done       <= done_next;
            // busy is registered alongside state so it follows it one-for-one.
            busy       <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
//-----------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed scenarios followed by a randomized phase. Expected count/busy/done
// come from a behavioural model that tracks the timer as an integer count plus
// "active" and "frozen" flags and applies the priority rules directly.
//-----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             start;
    logic             pause;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_count  = 0;
    int m_reload = 0;
    bit m_active = 1'b0;
    bit m_frozen = 1'b0;
    bit m_done   = 1'b0;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .data        (data),
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Applies the timer's rules to the model for one clock edge, using the
    // input values present at that edge.
    task automatic model_edge();
        m_done = 1'b0;
        if (rst) begin
            m_count = 0; m_reload = 0; m_active = 0; m_frozen = 0;
        end else if (load) begin
            m_count = int'(data); m_reload = int'(data); m_active = 0; m_frozen = 0;
        end else if (stop && m_active) begin
            m_active = 0; m_frozen = 0;
        end else if (!m_active) begin
            if (start && m_count > 0) m_active = 1;
        end else if (m_frozen) begin
            if (!pause) m_frozen = 0;
        end else if (pause) begin
            m_frozen = 1;
        end else if (m_count > 1) begin
            m_count = m_count - 1;
        end else begin
            m_done = 1;
            if (auto_reload) m_count = m_reload;
            else begin m_count = 0; m_active = 0; end
        end
    endtask

    // One clock edge: advance model, then compare #1 after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".count"}, 32'(count), 32'(m_count));
        check({tag, ".busy"},  32'(busy),  32'(m_active));
        check({tag, ".done"},  32'(done),  32'(m_done));
    endtask

    task automatic quiet();
        rst = 0; load = 0; data = '0; start = 0; pause = 0; stop = 0;
    endtask

    task automatic do_load(input int v, input string tag);
        quiet(); load = 1; data = WIDTH'(v);
        tick(tag);
        load = 0;
    endtask

    task automatic do_start(input string tag);
        quiet(); start = 1;
        tick(tag);
        start = 0;
    endtask

    task automatic idle_ticks(input int n, input string tag);
        quiet();
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    int seq1 [7] = '{5, 5, 4, 3, 2, 1, 0};
    int seq2 [8] = '{3, 3, 2, 1, 3, 2, 1, 3};
    int done_cnt;

    initial begin
        quiet(); auto_reload = 0;

        // Reset state
        rst = 1;
        tick("reset");
        check("reset.count_const", 32'(count), 32'd0);
        check("reset.busy_const",  32'(busy),  32'd0);
        check("reset.done_const",  32'(done),  32'd0);
        rst = 0;

        // 1: load 5, start, count to zero
        do_load(5, "t1.load");
        check("t1.seq0", 32'(count), 32'(seq1[0]));
        do_start("t1.start");
        check("t1.seq1", 32'(count), 32'(seq1[1]));
        check("t1.busy_run", 32'(busy), 32'd1);
        for (int i = 2; i < 7; i++) begin
            tick("t1.run");
            check("t1.seq", 32'(count), 32'(seq1[i]));
            check("t1.done", 32'(done), (i == 6) ? 32'd1 : 32'd0);
        end
        check("t1.busy_end", 32'(busy), 32'd0);
        tick("t1.after");
        check("t1.done_once", 32'(done), 32'd0);

        // 2: periodic with period 3
        auto_reload = 1;
        do_load(3, "t2.load");
        do_start("t2.start");
        done_cnt = 0;
        for (int i = 2; i < 8; i++) begin
            tick("t2.run");
            check("t2.seq", 32'(count), 32'(seq2[i]));
            check("t2.busy", 32'(busy), 32'd1);
            if (done) done_cnt++;
        end
        check("t2.done_count", 32'(done_cnt), 32'd2);
        stop = 1; tick("t2.stop"); stop = 0;
        auto_reload = 0;

        // 3: pause for 2 cycles at count 4
        do_load(6, "t3.load");
        do_start("t3.start");
        idle_ticks(2, "t3.run");
        check("t3.at4", 32'(count), 32'd4);
        pause = 1; tick("t3.pause"); tick("t3.pause");
        pause = 0; tick("t3.resume");
        check("t3.hold", 32'(count), 32'd4);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick("t3.run");
            if (done) done_cnt++;
        end
        check("t3.single_done", 32'(done_cnt), 32'd1);

        // 4: load while running at 2
        do_load(5, "t4.load");
        do_start("t4.start");
        idle_ticks(3, "t4.run");
        check("t4.at2", 32'(count), 32'd2);
        do_load(9, "t4.reload");
        check("t4.count9", 32'(count), 32'd9);
        check("t4.busy0", 32'(busy), 32'd0);
        idle_ticks(12, "t4.idle");

        // 5: start at zero refused; stop and resume
        do_load(0, "t5.load0");
        do_start("t5.start0");
        check("t5.busy0", 32'(busy), 32'd0);
        do_load(5, "t5.load");
        do_start("t5.start");
        idle_ticks(2, "t5.run");
        stop = 1; tick("t5.stop"); stop = 0;
        check("t5.count3", 32'(count), 32'd3);
        idle_ticks(2, "t5.held");
        do_start("t5.restart");
        idle_ticks(4, "t5.resume");

        // Full-scale load counts down normally
        do_load(31, "fs.load");
        do_start("fs.start");
        idle_ticks(32, "fs.run");

        // 6: reset mid-run at count 1 with auto_reload
        auto_reload = 1;
        do_load(2, "t6.load");
        do_start("t6.start");
        tick("t6.run");
        check("t6.at1", 32'(count), 32'd1);
        rst = 1; tick("t6.rst"); rst = 0;
        check("t6.done0", 32'(done), 32'd0);
        idle_ticks(3, "t6.after");
        auto_reload = 0;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            load        = ($urandom_range(0, 15) == 0);
            data        = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3))
                                                      : WIDTH'($urandom);
            start       = ($urandom_range(0, 2) == 0);
            pause       = ($urandom_range(0, 5) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            auto_reload = $urandom_range(0, 1) == 1;
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
